// File: rtl/colocviu_pkg.sv
// Shared definitions for the consecutive-ones run detector.
package colocviu_pkg;

  // Run-length states; the encoding value equals the number of consecutive
  // 1 samples seen, saturating at FOUR.
  typedef enum logic [2:0] {
    IDLE  = 3'b000,
    ONE   = 3'b001,
    TWO   = 3'b010,
    THREE = 3'b011,
    FOUR  = 3'b100
  } state_t;

  // Default number of consecutive 1 samples before the flag asserts.
  localparam int RUN_LEN_DEFAULT = 4;

endpackage : colocviu_pkg

// File: rtl/colocviu_run4.sv
// Consecutive-ones run detector: Q4 is a registered flag that is high while
// the serial input A has been 1 on at least RUN_LEN consecutive rising edges.
module colocviu_run4
  import colocviu_pkg::*;
#(
  parameter int RUN_LEN = RUN_LEN_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,   // asynchronous, active-high
  input  logic A,
  output logic Q4
);

  // State whose encoding matches the required run length (FOUR for 4).
  localparam state_t RUN_STATE = state_t'(3'(RUN_LEN));

  state_t state;
  state_t state_next;

  // State register; reset is asynchronous and active-high.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state <= IDLE;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values, independent of process ordering.
      state <= state_next;
    end
  end

  // Next-state decode: a 0 restarts counting, a 1 advances and saturates.
  always_comb begin
    // NOTE: default assignment first so no path leaves state_next unassigned,
    // which would otherwise infer a latch.
    state_next = IDLE;
    case (state)
      IDLE:    if (A) state_next = ONE;
      ONE:     if (A) state_next = TWO;
      TWO:     if (A) state_next = THREE;
      THREE:   if (A) state_next = FOUR;
      FOUR:    if (A) state_next = FOUR;
      default: state_next = IDLE;   // unused encodings recover to IDLE
    endcase
  end

  // Output register loaded from the next-state decode, so Q4 is glitch-free
  // and changes on the same edge as the state register.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      Q4 <= 1'b0;
    end else begin
      Q4 <= (state_next == RUN_STATE);
    end
  end

endmodule : colocviu_run4

// File: tb/tb_colocviu_run4.sv
// Directed self-checking bench for colocviu_run4 with a run-length reference
// model feeding an expected-value queue.
module tb_colocviu_run4;

  localparam int RUN_LEN = 4;

  logic clk;
  logic rst_n;
  logic A;
  logic Q4;

  int   passed = 0;
  int   total  = 0;
  int   run    = 0;        // model: consecutive 1 samples seen
  bit   exp_q[$];          // scoreboard of expected Q4 values
  int   highs;

  colocviu_run4 #(.RUN_LEN(RUN_LEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .A     (A),
    .Q4    (Q4)
  );

  // Shared clock generator, semiperiod 10.
  initial begin
    clk = 1'b0;
    forever #10 clk = ~clk;
  end

  // Pop the oldest expectation and compare it with the current Q4.
  task automatic compare(input string tag);
    bit exp;
    total++;
    if (exp_q.size() == 0) begin
      $error("FAIL %s: scoreboard empty, Q4=%b", tag, Q4);
    end else begin
      exp = exp_q.pop_front();
      assert (Q4 === exp) passed++;
      else $error("FAIL %s: Q4=%b expected %b", tag, Q4, exp);
    end
  endtask

  // Drive A at the falling edge, predict Q4 after the next rising edge,
  // then compare at the following falling edge.
  task automatic cyc(input logic a, input string tag);
    A = a;
    if (rst_n)      run = 0;
    else if (a)     run = (run < 100) ? run + 1 : run;
    else            run = 0;
    exp_q.push_back(run >= RUN_LEN);
    @(posedge clk);
    @(negedge clk);
    compare(tag);
  endtask

  // Repeat a value for n cycles.
  task automatic seg(input logic a, input int n, input string tag);
    for (int i = 0; i < n; i++) cyc(a, tag);
  endtask

  initial begin
    rst_n = 1'b1;
    A     = 1'b0;
    @(negedge clk);

    // Reset held with A toggling: Q4 stays 0.
    for (int i = 0; i < 4; i++) cyc(i[0], "reset_hold");

    // Release with A=0.
    rst_n = 1'b0;
    seg(1'b0, 2, "post_release");

    // Short runs never reach the threshold.
    seg(1'b1, 2, "short_2");
    seg(1'b0, 4, "short_gap");
    seg(1'b1, 1, "short_1");
    seg(1'b0, 3, "short_gap");
    seg(1'b1, 3, "short_3");
    seg(1'b0, 4, "short_gap");

    // Exact run of 4: one-cycle pulse.
    highs = 0;
    for (int i = 0; i < 8; i++) begin
      cyc(i < 4, "exact_run");
      if (Q4 === 1'b1) highs++;
    end
    total++;
    assert (highs == 1) passed++;
    else $error("FAIL exact_pulse_len: %0d cycles expected 1", highs);

    // Long run of 7: four-cycle pulse, falls after the first 0 sample.
    highs = 0;
    for (int i = 0; i < 9; i++) begin
      cyc(i < 7, "long_run");
      if (Q4 === 1'b1) highs++;
    end
    total++;
    assert (highs == 4) passed++;
    else $error("FAIL long_pulse_len: %0d cycles expected 4", highs);

    // Interrupted run: 1,1,1,0,1,1,1,1 -> high only after the 8th sample.
    cyc(1'b1, "interrupt");
    cyc(1'b1, "interrupt");
    cyc(1'b1, "interrupt");
    cyc(1'b0, "interrupt");
    seg(1'b1, 4, "interrupt");
    seg(1'b0, 2, "interrupt_end");

    // Mid-run reset: build a run until Q4=1, then reset between edges.
    seg(1'b1, 5, "midrun_build");
    #2 rst_n = 1'b1;
    #1;
    run = 0;
    exp_q.push_back(1'b0);
    compare("midrun_async_clear");
    @(negedge clk);
    cyc(1'b1, "midrun_held");
    rst_n = 1'b0;
    seg(1'b1, 5, "midrun_recount");
    seg(1'b0, 2, "final_zero");

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule : tb_colocviu_run4

// File: doc/colocviu_run4.md
# colocviu_run4

Consecutive-ones run detector. It samples serial input `A` on every rising clock edge and asserts `Q4` once `A` has been 1 on four or more consecutive samples. The block sits as a leaf in the lab design. It is driven by the shared clock/reset generator, which uses a semiperiod of 10 time units.

## Interface
Parameters:
- `RUN_LEN`, default 4: number of consecutive 1 samples required before `Q4` asserts. Only the value 4 is verified.

Ports:
- `clk`, input, 1 bit: clock; all state changes on the rising edge.
- `rst_n`, input, 1 bit: reset, asynchronous, active-high.
- `A`, input, 1 bit: serial data, synchronous to `clk`, sampled on each rising edge.
- `Q4`, output, 1 bit: registered run-detected flag.

Reset is `rst_n`, asynchronous, active-high; the clock is `clk`.

## Operation
- Moore FSM with states:
  - IDLE: last sample was 0, or reset.
  - ONE: one consecutive 1.
  - TWO: two consecutive 1s.
  - THREE: three consecutive 1s.
  - FOUR: four or more consecutive 1s.
- Transitions on each rising edge, based on the sampled `A`:
  - `A`=0 from any state -> IDLE.
  - `A`=1: IDLE->ONE, ONE->TWO, TWO->THREE, THREE->FOUR, FOUR->FOUR (saturates, no wrap).
- `Q4`=1 exactly when the state is FOUR, else 0.
- `Q4` is driven from a flip-flop loaded with the next-state decode, so it is glitch-free and aligned with the state register.
- Illegal or unused state encodings go to IDLE on the next edge, with `Q4`=0.
- A single 0 anywhere in a run restarts counting; no partial credit carries over.

## Timing
- Reset (`rst_n`=1) forces, asynchronously: state=IDLE, `Q4`=0. Both hold while reset is asserted, regardless of `A` or `clk`.
- Release is on the falling edge of `rst_n`. The first sample is taken at the first rising `clk` after release.
- Latency:
  - If `A` is 1 at rising edges k, k+1, k+2 and k+3, `Q4` rises right after edge k+3.
  - `Q4` stays 1 while `A` stays 1.
  - `Q4` falls right after the first edge that samples `A`=0, so the fall has one cycle of latency.
- A 1 run of length L gives a `Q4` pulse of max(0, L-3) cycles.
- Reset asserted mid-run clears `Q4` immediately. After release, counting restarts from IDLE even if `A` is still 1.
- Outputs change only on a rising `clk` or on reset assertion, never combinationally from `A`.

## Structure
- Shared package `colocviu_pkg`:
  - state enum/encoding: IDLE, ONE, TWO, THREE, FOUR; 3-bit binary, IDLE = 3'b000.
  - `RUN_LEN` default constant.
- One module, no sub-modules. The FSM is split into a state register process, a next-state combinational process and the output register.
- The clock/reset generator is a bench-only component with semiperiod 10. It is not part of the synthesizable block.

## Test plan
- Reset: hold `rst_n`=1 with `A` toggling -> `Q4`=0 throughout; after release, with `A`=0 -> `Q4`=0.
- Short runs: `A`=1 for 2 cycles, 0 for 4, 1 for 1, 0 for 3, 1 for 3, 0 for 4 -> `Q4` stays 0 for the whole sequence.
- Exact run: `A`=1 for 4 cycles, then 0 for 4 -> `Q4` is 1 for exactly 1 cycle, starting after the 4th 1-sample, then 0.
- Long run: `A`=1 for 7 cycles, then 0 -> `Q4` is high for 4 cycles, and drops the cycle after the first 0 sample.
- Interrupted run: `A` = 1,1,1,0,1,1,1,1 -> `Q4` stays 0 until after the 8th sample, then goes 1.
- Mid-run reset: `A`=1 continuously; assert reset while `Q4`=1 -> `Q4` drops to 0 immediately; after release it reasserts only after 4 further edges.
